// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Pipeline stage 4 of the 16-bit CPU. Captures the ALU-stage
//             bundle, performs the LW/SW data-memory access over a
//             request/acknowledge port with a timeout, resolves BEQ/JUMP,
//             and presents a registered writeback/branch bundle for one cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RST            clock, asynchronous active-high reset
//    STAGE4IN            capture request from the sequencer (used in IDLE)
//    IRIN/PCIN           instruction and PC from the ALU stage
//    DATAIN/ADDRIN       ALU result/store data/compare flag, address/target
//    MEM_REQ/WE/ADDR/WDATA  data-memory request side
//    MEM_RDATA/MEM_ACK   data-memory response side
//    BUSY                high while a memory access is outstanding
//    DONE                one-cycle pulse, output bundle valid
//    IROUT/PCOUT/RESULT/WB_EN/BRANCH_TAKEN/BRANCH_TARGET/FAULT  bundle
// ============================================================================
module mem_stage #(
  parameter int unsigned TIMEOUT = 15  // legal range 1..255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STAGE4IN,
  input  logic [15:0] IRIN,
  input  logic [15:0] PCIN,
  input  logic [15:0] DATAIN,
  input  logic [15:0] ADDRIN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] IROUT,
  output logic [15:0] PCOUT,
  output logic [15:0] RESULT,
  output logic        WB_EN,
  output logic        BRANCH_TAKEN,
  output logic [15:0] BRANCH_TARGET,
  output logic        FAULT
);

  // Opcode field IR[15:12] and the shared CPU opcode encodings.
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JUMP = 4'hA;

  // The counter reaches TO_LAST on the (TIMEOUT-1)-th un-acked edge, so the
  // next un-acked edge is the TIMEOUT-th one and raises the fault.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] ir_q, pc_q;
  logic        is_lw_q;
  logic        mem_req_q, mem_we_q, busy_q, done_q;
  logic [15:0] mem_addr_q, mem_wdata_q;
  logic [15:0] irout_q, pcout_q, result_q, btgt_q;
  logic        wb_en_q, bt_q, fault_q;

  // Decode of the incoming instruction for the non-memory completion path.
  logic [3:0]  op_d;
  logic        is_mem_d;
  logic        known_d;
  logic [15:0] result_d, btgt_d;
  logic        wb_en_d, bt_d;

  assign op_d     = IRIN[15:12];
  assign is_mem_d = (op_d == OP_LW) || (op_d == OP_SW);

  always_comb begin
    result_d = 16'h0000;
    btgt_d   = 16'h0000;
    wb_en_d  = 1'b0;
    bt_d     = 1'b0;
    known_d  = 1'b1;
    case (op_d)
      OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_ADDI: begin
        result_d = DATAIN;
        wb_en_d  = 1'b1;
      end
      OP_BEQ: begin
        // The ALU stage reports equality as an all-ones flag word.
        if (DATAIN == 16'hFFFF) begin
          bt_d   = 1'b1;
          btgt_d = ADDRIN;
        end
      end
      OP_JUMP: begin
        bt_d   = 1'b1;
        btgt_d = DATAIN;
      end
      default: known_d = 1'b0;  // bubble / unknown: whole bundle stays 0
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      ir_q        <= 16'h0000;
      pc_q        <= 16'h0000;
      is_lw_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irout_q     <= 16'h0000;
      pcout_q     <= 16'h0000;
      result_q    <= 16'h0000;
      btgt_q      <= 16'h0000;
      wb_en_q     <= 1'b0;
      bt_q        <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (STAGE4IN) begin
            ir_q    <= IRIN;
            pc_q    <= PCIN;
            is_lw_q <= (op_d == OP_LW);
            if (is_mem_d) begin
              state_q     <= S_ACCESS;
              cnt_q       <= 8'd0;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (op_d == OP_SW);
              mem_addr_q  <= ADDRIN;
              mem_wdata_q <= (op_d == OP_SW) ? DATAIN : 16'h0000;
            end else begin
              state_q  <= S_COMPLETE;
              done_q   <= 1'b1;
              irout_q  <= known_d ? IRIN : 16'h0000;
              pcout_q  <= known_d ? PCIN : 16'h0000;
              result_q <= result_d;
              wb_en_q  <= wb_en_d;
              bt_q     <= bt_d;
              btgt_q   <= btgt_d;
              fault_q  <= 1'b0;
            end
          end
        end

        S_ACCESS: begin
          // An ack on the timeout edge wins over the fault.
          if (MEM_ACK || (cnt_q == TO_LAST)) begin
            state_q     <= S_COMPLETE;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            done_q      <= 1'b1;
            irout_q     <= ir_q;
            pcout_q     <= pc_q;
            fault_q     <= ~MEM_ACK;
            result_q    <= (is_lw_q && MEM_ACK) ? MEM_RDATA : 16'h0000;
            wb_en_q     <= is_lw_q && MEM_ACK;
            bt_q        <= 1'b0;
            btgt_q      <= 16'h0000;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin  // S_COMPLETE: bundle is shown for exactly one cycle
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          irout_q  <= 16'h0000;
          pcout_q  <= 16'h0000;
          result_q <= 16'h0000;
          wb_en_q  <= 1'b0;
          bt_q     <= 1'b0;
          btgt_q   <= 16'h0000;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_REQ       = mem_req_q;
  assign MEM_WE        = mem_we_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_WDATA     = mem_wdata_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign IROUT         = irout_q;
  assign PCOUT         = pcout_q;
  assign RESULT        = result_q;
  assign WB_EN         = wb_en_q;
  assign BRANCH_TAKEN  = bt_q;
  assign BRANCH_TARGET = btgt_q;
  assign FAULT         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage (TIMEOUT=4). Stimulus pushes
//             the hand-computed bundle into a scoreboard queue; a monitor
//             pops and compares whenever DONE is high. A memory responder
//             acks after a programmable number of request cycles and checks
//             the request-side signals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int unsigned TO = 4;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JUMP = 4'hA;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STAGE4IN;
  logic [15:0] IRIN, PCIN, DATAIN, ADDRIN;
  logic        MEM_REQ, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        MEM_ACK;
  logic        BUSY, DONE;
  logic [15:0] IROUT, PCOUT, RESULT, BRANCH_TARGET;
  logic        WB_EN, BRANCH_TAKEN, FAULT;

  mem_stage #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .STAGE4IN(STAGE4IN),
    .IRIN(IRIN), .PCIN(PCIN), .DATAIN(DATAIN), .ADDRIN(ADDRIN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .BUSY(BUSY), .DONE(DONE), .IROUT(IROUT), .PCOUT(PCOUT),
    .RESULT(RESULT), .WB_EN(WB_EN), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] ir, pc, result, btgt;
    logic        wb, bt, fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Memory responder controls and expected request-side values.
  int          ack_after      = 0;  // 0 = never ack
  int          exp_req_cycles = 0;  // 0 = do not check request length
  logic        exp_we         = 1'b0;
  logic [15:0] exp_addr       = 16'h0000;
  logic [15:0] exp_wdata      = 16'h0000;
  int          req_cycles     = 0;
  logic        req_prev       = 1'b0;
  logic        prev_done      = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [15:0] ir, input logic [15:0] pc,
                              input logic [15:0] res, input logic wb,
                              input logic bt, input logic [15:0] btgt,
                              input logic fault);
    exp_t e;
    e.ir = ir; e.pc = pc; e.result = res; e.wb = wb;
    e.bt = bt; e.btgt = btgt; e.fault = fault;
    return e;
  endfunction

  task automatic issue(input logic [15:0] ir, input logic [15:0] pc,
                       input logic [15:0] data, input logic [15:0] addr,
                       input exp_t e);
    bit got;
    @(negedge CLK);
    IRIN = ir; PCIN = pc; DATAIN = data; ADDRIN = addr;
    STAGE4IN = 1'b1;
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) got = 1'b1;
    end
    STAGE4IN = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL done_wait: got no DONE within 40 cycles for ir %h", ir);
    end
    repeat (2) @(negedge CLK);
  endtask

  // Memory responder: acks on the ack_after-th request cycle.
  initial begin
    MEM_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (MEM_REQ) begin
        req_cycles++;
        chk("mem_we",    {15'b0, MEM_WE}, {15'b0, exp_we});
        chk("mem_addr",  MEM_ADDR, exp_addr);
        chk("mem_wdata", MEM_WDATA, exp_wdata);
        chk("busy_acc",  {15'b0, BUSY}, 16'h0001);
        MEM_ACK = (ack_after > 0) && (req_cycles == ack_after);
      end else begin
        if (req_prev && exp_req_cycles > 0)
          chk("req_cycles", 16'(req_cycles), 16'(exp_req_cycles));
        req_cycles = 0;
        MEM_ACK    = 1'b0;
      end
      req_prev = MEM_REQ;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DONE) begin
        chk("done_pulse", {15'b0, prev_done}, 16'h0000);
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got DONE with ir %h, required no DONE", IROUT);
        end else begin
          e = sb_q.pop_front();
          chk("irout",   IROUT, e.ir);
          chk("pcout",   PCOUT, e.pc);
          chk("result",  RESULT, e.result);
          chk("wb_en",   {15'b0, WB_EN}, {15'b0, e.wb});
          chk("br_taken",{15'b0, BRANCH_TAKEN}, {15'b0, e.bt});
          chk("br_tgt",  BRANCH_TARGET, e.btgt);
          chk("fault",   {15'b0, FAULT}, {15'b0, e.fault});
          chk("req_done",{14'b0, MEM_REQ, BUSY}, 16'h0000);
        end
      end else begin
        chk("idle_bundle",
            IROUT | PCOUT | RESULT | BRANCH_TARGET | {13'b0, WB_EN, BRANCH_TAKEN, FAULT},
            16'h0000);
      end
      prev_done = DONE;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; STAGE4IN = 1'b0;
    IRIN = 16'h0; PCIN = 16'h0; DATAIN = 16'h0; ADDRIN = 16'h0;
    MEM_RDATA = 16'h0;
    repeat (2) @(negedge CLK);
    chk("rst_outs", {12'b0, MEM_REQ, BUSY, DONE, WB_EN}, 16'h0000);
    chk("rst_bundle", RESULT | IROUT | PCOUT | MEM_ADDR, 16'h0000);
    RST = 1'b0;
    @(negedge CLK);

    // ALU pass-through ops.
    issue({OP_ADD, 12'h123}, 16'h0010, 16'h1234, 16'h0000,
          mk({OP_ADD, 12'h123}, 16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0));
    issue({OP_SUB, 12'h456}, 16'h0012, 16'hF00D, 16'h0077,
          mk({OP_SUB, 12'h456}, 16'h0012, 16'hF00D, 1'b1, 1'b0, 16'h0000, 1'b0));
    issue({OP_OR, 12'h001}, 16'h0014, 16'h0F0F, 16'h0000,
          mk({OP_OR, 12'h001}, 16'h0014, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b0));

    // LW with ack on the third request cycle.
    ack_after = 3; exp_req_cycles = 3; exp_we = 1'b0;
    exp_addr = 16'h0020; exp_wdata = 16'h0000; MEM_RDATA = 16'hBEEF;
    issue({OP_LW, 12'h210}, 16'h0016, 16'h5555, 16'h0020,
          mk({OP_LW, 12'h210}, 16'h0016, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0));

    // SW with immediate ack.
    ack_after = 1; exp_req_cycles = 1; exp_we = 1'b1;
    exp_addr = 16'h0010; exp_wdata = 16'h00AA; MEM_RDATA = 16'h1111;
    issue({OP_SW, 12'h320}, 16'h0018, 16'h00AA, 16'h0010,
          mk({OP_SW, 12'h320}, 16'h0018, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));

    // Branches and a bubble.
    issue({OP_BEQ, 12'h012}, 16'h001A, 16'hFFFF, 16'h0008,
          mk({OP_BEQ, 12'h012}, 16'h001A, 16'h0000, 1'b0, 1'b1, 16'h0008, 1'b0));
    issue({OP_BEQ, 12'h034}, 16'h001C, 16'h0000, 16'h0030,
          mk({OP_BEQ, 12'h034}, 16'h001C, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
    issue({OP_JUMP, 12'h100}, 16'h001E, 16'h0100, 16'h0000,
          mk({OP_JUMP, 12'h100}, 16'h001E, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0));
    issue(16'h0000, 16'h0000, 16'h4321, 16'h8765,
          mk(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));

    // Timeout: no ack for TIMEOUT edges.
    ack_after = 0; exp_req_cycles = 4; exp_we = 1'b0;
    exp_addr = 16'h0044; exp_wdata = 16'h0000; MEM_RDATA = 16'hDEAD;
    issue({OP_LW, 12'h240}, 16'h0020, 16'h0000, 16'h0044,
          mk({OP_LW, 12'h240}, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1));

    // Ack on the timeout edge itself wins.
    ack_after = 4; exp_req_cycles = 4; exp_addr = 16'h0046; MEM_RDATA = 16'hCAFE;
    issue({OP_LW, 12'h250}, 16'h0022, 16'h0000, 16'h0046,
          mk({OP_LW, 12'h250}, 16'h0022, 16'hCAFE, 1'b1, 1'b0, 16'h0000, 1'b0));

    // Reset in the middle of an access.
    ack_after = 0; exp_req_cycles = 0; exp_we = 1'b0;
    exp_addr = 16'h0040; exp_wdata = 16'h0000;
    @(negedge CLK);
    IRIN = {OP_LW, 12'h260}; PCIN = 16'h0024; DATAIN = 16'h0; ADDRIN = 16'h0040;
    STAGE4IN = 1'b1;
    @(posedge CLK);
    #1;
    STAGE4IN = 1'b0;
    chk("acc_req", {14'b0, MEM_REQ, BUSY}, 16'h0003);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("rst_mid_ctl", {12'b0, MEM_REQ, BUSY, DONE, MEM_WE}, 16'h0000);
    chk("rst_mid_addr", MEM_ADDR, 16'h0000);
    chk("rst_mid_bundle", RESULT | IROUT | PCOUT | {15'b0, FAULT}, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Stage accepts a new capture after reset.
    issue({OP_ADD, 12'h777}, 16'h0030, 16'hA5A5, 16'h0000,
          mk({OP_ADD, 12'h777}, 16'h0030, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b0));

    repeat (3) @(negedge CLK);
    chk("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
